// File: rtl/alu_pipe.sv
// Pipelined ALU with operand/result valid-ready handshakes, flag outputs and an
// iterative shift-add multiplier that stalls the operand side while it runs.
module alu_pipe #(
  parameter int WIDTH  = 64,
  parameter int MUL_EN = 1,
  parameter int SHW    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam logic [3:0] OP_MUL = 4'b1001;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam int         CW     = SHW + 1;

  typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_WAIT} state_e;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             overflow_q, overflow_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;

  logic [WIDTH-1:0] sum, diff, acc_nx;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf, alu_ill, is_mul;
  logic             slot_free, accept;

  assign sum   = data1 + data2;
  assign diff  = data1 - data2;
  assign shamt = data2[SHW-1:0];

  // Single-cycle datapath; MUL only raises is_mul and is handled by the FSM.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    is_mul  = 1'b0;
    case (op)
      OP_AND: alu_res = data1 & data2;
      OP_OR:  alu_res = data1 | data2;
      OP_XOR: alu_res = data1 ^ data2;
      OP_NOR: alu_res = ~(data1 | data2);
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (data1[WIDTH-1] == data2[WIDTH-1]) && (sum[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (data1[WIDTH-1] != data2[WIDTH-1]) && (diff[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
      OP_SLL: alu_res = data1 << shamt;
      OP_SRL: alu_res = data1 >> shamt;
      OP_SRA: alu_res = $unsigned($signed(data1) >>> shamt);
      OP_MUL: begin
        if (MUL_EN != 0) is_mul  = 1'b1;
        else             alu_ill = 1'b1;
      end
      default: alu_ill = 1'b1;
    endcase
  end

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == IDLE) && slot_free;
  assign accept    = in_valid && in_ready;
  assign acc_nx    = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    logic             load;
    logic [WIDTH-1:0] ld_res;
    logic             ld_ovf, ld_ill;
    load        = 1'b0;
    ld_res      = '0;
    ld_ovf      = 1'b0;
    ld_ill      = 1'b0;
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    overflow_d  = overflow_q;
    illegal_d   = illegal_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    count_d     = count_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_d  = MUL_RUN;
            mcand_d  = data1;
            mplier_d = data2;
            acc_d    = '0;
            count_d  = CW'(WIDTH);
          end else begin
            load   = 1'b1;
            ld_res = alu_res;
            ld_ovf = alu_ovf;
            ld_ill = alu_ill;
          end
        end
      end
      MUL_RUN: begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - 1'b1;
        if (count_q == CW'(1)) begin
          if (slot_free) begin
            load    = 1'b1;
            ld_res  = acc_nx;
            state_d = IDLE;
          end else begin
            state_d = MUL_WAIT;
          end
        end
      end
      MUL_WAIT: begin
        if (out_ready) begin
          load    = 1'b1;
          ld_res  = acc_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A completion always wins over a consume, so same-edge handoff has no bubble.
    if (load) begin
      out_valid_d = 1'b1;
      result_d    = ld_res;
      zero_d      = (ld_res == '0);
      overflow_d  = ld_ovf;
      illegal_d   = ld_ill;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: directed literal checks plus randomized traffic compared
// every cycle against a transaction-level model built from plain arithmetic.
module tb_alu_pipe;
  localparam int W = 64;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] data1, data2, result;
  logic [3:0]   op;
  logic         zero, overflow, illegal;

  int total = 0;
  int bad   = 0;

  alu_pipe #(.WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .data1(data1), .data2(data2), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .overflow(overflow), .illegal(illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // Reference ALU: results and signed overflow from exact-width arithmetic.
  function automatic void ref_alu(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic v, output logic il);
    logic signed [W:0] w;
    logic signed [W:0] lo, hi;
    hi = $signed({2'b00, {(W-1){1'b1}}});
    lo = $signed({2'b11, {(W-1){1'b0}}});
    r = '0; v = 1'b0; il = 1'b0;
    case (o)
      4'd0:  r = a & b;
      4'd1:  r = a | b;
      4'd2:  begin w = $signed({a[W-1], a}) + $signed({b[W-1], b}); r = w[W-1:0]; v = (w > hi) || (w < lo); end
      4'd3:  r = a ^ b;
      4'd4:  r = a << b[5:0];
      4'd5:  r = a >> b[5:0];
      4'd6:  begin w = $signed({a[W-1], a}) - $signed({b[W-1], b}); r = w[W-1:0]; v = (w > hi) || (w < lo); end
      4'd7:  r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      4'd8:  r = $signed(a) >>> b[5:0];
      4'd9:  r = a * b;
      4'd12: r = ~(a | b);
      default: il = 1'b1;
    endcase
  endfunction

  // Transaction model: outstanding-multiply countdown plus one output slot.
  logic         m_ov, m_zero, m_ovf, m_ill, waiting;
  logic [W-1:0] m_res, mul_val;
  int           mul_left;

  always @(posedge clock or negedge reset_n) begin : model
    logic [W-1:0] r;
    logic         v, il, ld, sf;
    if (!reset_n) begin
      m_ov <= 1'b0; m_res <= '0; m_zero <= 1'b1; m_ovf <= 1'b0; m_ill <= 1'b0;
      mul_left <= 0; waiting <= 1'b0; mul_val <= '0;
    end else begin
      sf = !m_ov || out_ready;
      ld = 1'b0; r = '0; v = 1'b0; il = 1'b0;
      if (mul_left > 0) begin
        mul_left <= mul_left - 1;
        if (mul_left == 1) begin
          if (sf) begin ld = 1'b1; r = mul_val; end
          else waiting <= 1'b1;
        end
      end else if (waiting) begin
        if (out_ready) begin ld = 1'b1; r = mul_val; waiting <= 1'b0; end
      end else if (in_valid && sf) begin
        if (op == 4'd9) begin
          mul_left <= W;
          mul_val  <= data1 * data2;
        end else begin
          ref_alu(op, data1, data2, r, v, il);
          ld = 1'b1;
        end
      end
      if (ld) begin
        m_ov <= 1'b1; m_res <= r; m_zero <= (r == '0); m_ovf <= v; m_ill <= il;
      end else if (out_ready) begin
        m_ov <= 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      chkb("cmp_in_ready", in_ready, (mul_left == 0 && !waiting) && (!m_ov || out_ready));
      chkb("cmp_out_valid", out_valid, m_ov);
      if (m_ov) begin
        chk("cmp_result", result, m_res);
        chkb("cmp_zero", zero, m_zero);
        chkb("cmp_overflow", overflow, m_ovf);
        chkb("cmp_illegal", illegal, m_ill);
      end
    end
  end

  task automatic drive(input logic v, input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = v; op = o; data1 = a; data2 = b;
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom % 6)
      0: return '0;
      1: return {W{1'b1}};
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      4: return 64'($urandom % 16);
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running want finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int viol;
    reset_n = 1'b0; out_ready = 1'b0;
    drive(1'b0, 4'd0, '0, '0);
    repeat (2) @(posedge clock);
    #1;
    chkb("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 64'd0);
    chkb("rst_zero", zero, 1'b1);
    chkb("rst_overflow", overflow, 1'b0);
    chkb("rst_illegal", illegal, 1'b0);
    reset_n = 1'b1;
    #1;
    chkb("rst_in_ready", in_ready, 1'b1);

    out_ready = 1'b1;
    drive(1'b1, 4'd2, 64'd5, 64'd7);
    step;
    drive(1'b0, 4'd0, '0, '0);
    chkb("add_valid", out_valid, 1'b1);
    chk("add_result", result, 64'd12);
    chkb("add_zero", zero, 1'b0);
    chkb("add_ovf", overflow, 1'b0);
    step;
    chkb("add_release", out_valid, 1'b0);

    drive(1'b1, 4'd6, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    step;
    chk("sub_ovf_result", result, 64'h8000_0000_0000_0000);
    chkb("sub_ovf_flag", overflow, 1'b1);
    drive(1'b1, 4'd6, 64'd9, 64'd9);
    step;
    chk("sub_zero_result", result, 64'd0);
    chkb("sub_zero_flag", zero, 1'b1);
    chkb("sub_zero_ovf", overflow, 1'b0);
    drive(1'b0, 4'd0, '0, '0);
    step;

    out_ready = 1'b0;
    drive(1'b1, 4'd0, 64'hF0, 64'h3C);
    step;
    chk("and_result", result, 64'h30);
    chkb("and_valid", out_valid, 1'b1);
    drive(1'b1, 4'd1, 64'h1, 64'h2);
    #1;
    chkb("hold_in_ready", in_ready, 1'b0);
    step;
    chk("hold_result", result, 64'h30);
    chkb("hold_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    #1;
    chkb("swap_in_ready", in_ready, 1'b1);
    step;
    chk("swap_result", result, 64'd3);
    chkb("swap_valid", out_valid, 1'b1);
    drive(1'b0, 4'd0, '0, '0);
    step;
    chkb("swap_release", out_valid, 1'b0);

    drive(1'b1, 4'd9, 64'd123456789, 64'd1000);
    step;
    drive(1'b0, 4'd0, '0, '0);
    viol = 0;
    repeat (63) begin
      step;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) viol++;
    end
    chk("mul_busy_viol", 64'(viol), 64'd0);
    step;
    chkb("mul_valid", out_valid, 1'b1);
    chk("mul_result", result, 64'd123456789000);
    step;

    out_ready = 1'b0;
    drive(1'b1, 4'd2, 64'd1, 64'd1);
    step;
    chk("pend_result", result, 64'd2);
    drive(1'b1, 4'd9, 64'd6, 64'd7);
    #1;
    chkb("pend_in_ready", in_ready, 1'b0);
    step;
    chk("pend_hold", result, 64'd2);
    chkb("pend_hold_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    step;
    drive(1'b0, 4'd0, '0, '0);
    out_ready = 1'b0;
    chkb("pend_consumed", out_valid, 1'b0);
    repeat (63) step;
    chkb("mul2_early", out_valid, 1'b0);
    step;
    chkb("mul2_valid", out_valid, 1'b1);
    chk("mul2_result", result, 64'd42);
    repeat (3) step;
    chkb("mul2_hold_valid", out_valid, 1'b1);
    chk("mul2_hold_result", result, 64'd42);
    out_ready = 1'b1;
    step;
    chkb("mul2_release", out_valid, 1'b0);

    drive(1'b1, 4'd8, 64'h8000_0000_0000_0000, 64'h104);
    step;
    chk("sra_result", result, 64'hF800_0000_0000_0000);
    drive(1'b1, 4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    step;
    chk("slt_result", result, 64'd1);
    drive(1'b1, 4'd15, 64'd123, 64'd456);
    step;
    chk("ill_result", result, 64'd0);
    chkb("ill_flag", illegal, 1'b1);
    chkb("ill_zero", zero, 1'b1);
    drive(1'b0, 4'd0, '0, '0);
    step;

    drive(1'b1, 4'd9, 64'd5, 64'd9);
    step;
    drive(1'b0, 4'd0, '0, '0);
    repeat (10) step;
    reset_n = 1'b0;
    #1;
    chkb("mrst_valid", out_valid, 1'b0);
    chk("mrst_result", result, 64'd0);
    chkb("mrst_zero", zero, 1'b1);
    reset_n = 1'b1;
    #1;
    chkb("mrst_in_ready", in_ready, 1'b1);
    drive(1'b1, 4'd2, 64'd2, 64'd2);
    step;
    drive(1'b0, 4'd0, '0, '0);
    chkb("mrst_add_valid", out_valid, 1'b1);
    chk("mrst_add_result", result, 64'd4);
    step;

    repeat (3000) begin
      logic [3:0] o;
      o = 4'($urandom % 16);
      if (o == 4'd9 && ($urandom % 4) != 0) o = 4'd2;
      drive(($urandom % 4) != 0, o, rnd_val(), rnd_val());
      out_ready = ($urandom % 4) != 0;
      step;
    end
    drive(1'b0, 4'd0, '0, '0);
    out_ready = 1'b1;
    repeat (80) step;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
